apb_master: RTL and testbench
=============================

# apb_master

APB requester that turns a simple valid/ready command port into APB3 transfers on psel/penable/pwrite/paddr/pwdata. It returns one response per command, carrying read data and error status. It sits directly upstream of the team's APB slave and drives its APB inputs. It gives test harnesses and the control core a single command-level entry point to the register space.

## Interface
- DATA_WIDTH, 32, width of cmd_wdata, pwdata, prdata, rsp_rdata
- ADDR_WIDTH, 32, width of cmd_addr, paddr
- TIMEOUT, 16, max wait cycles in ACCESS with pready low before abort; 0 disables the timeout
- pclk  in  1  clock; all logic on the rising edge
- presetn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted on an edge where cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts
- rsp_err  out  1  pslverr sampled at completion, or 1 on timeout
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB completion
- pslverr  in  1  APB error

## Operation
- The FSM has three states, IDLE, SETUP and ACCESS, encoded 2'b00, 2'b01, 2'b11.
- **IDLE**
  - psel=0, penable=0, cmd_ready=1.
  - On cmd_valid: latch cmd_write, cmd_addr, cmd_wdata into paddr/pwrite/pwdata, then go to SETUP.
- **SETUP**
  - psel=1, penable=0, cmd_ready=0.
  - Always goes to ACCESS on the next edge.
- **ACCESS**
  - psel=1, penable=1, cmd_ready=0.
  - pready=1: go to IDLE. Register rsp_valid=1, rsp_err=pslverr, and rsp_rdata=prdata for a read or 0 for a write.
  - pready=0: increment the wait counter.
  - Counter == TIMEOUT (TIMEOUT≠0): go to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0.
- The wait counter is clog2(TIMEOUT+1) bits wide. It clears on entry to SETUP and saturates; it never wraps.
- paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS. Outside a transfer they hold their last values.
- rsp_valid is high for exactly one cycle per accepted command. There is no response backpressure.
- rsp_rdata and rsp_err hold their values until the next response.
- A pslverr sampled while pready=0 is ignored.
- cmd_ready is combinational, cmd_ready = (state==IDLE). Commands offered while presetn is low are ignored.
- **Reset**, asynchronous and effective at any time including mid-transfer:
  - state=IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, wait counter all 0.
  - An in-flight command is dropped and produces no response.

## Timing
- Command accepted at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2.
- With pready=1 in cycle 2: rsp_valid high in cycle 3 and the state is IDLE in cycle 3.
- Each wait cycle (pready low) adds one cycle of latency.
- Minimum issue interval is 3 cycles per command. With cmd_valid held high, the next command is accepted at the edge ending cycle 3 and its SETUP is cycle 4.
- Timeout with TIMEOUT=N: rsp_valid is asserted N+1 cycles after ACCESS entry, with psel/penable low in that same cycle.
- rsp_valid and cmd_ready are both high in the completion cycle. A new command can be accepted in that cycle.

## Structure
- Shared package apb_pkg holds:
  - state encodings IDLE/SETUP/ACCESS;
  - default DATA_WIDTH/ADDR_WIDTH;
  - the timeout counter width function.
- The slave side uses the same package.
- One natural sub-module is apb_master_timer: the saturating wait counter with clear, enable and expired outputs.
- Everything else lives in apb_master.

## Test plan
- **Write, zero wait.** Write 0xDEADBEEF to 0x10 with pready tied high.
  - psel high in cycles 1–2, penable high in cycle 2, pwdata=0xDEADBEEF.
  - rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- **Read, two waits.** Read 0x20 with pready low for 2 ACCESS cycles, prdata=0x12345678 when pready rises.
  - rsp_valid in cycle 5 with rsp_rdata=0x12345678.
  - paddr stable throughout.
- **Slave error.** Read with pslverr=1 and pready=1.
  - rsp_err=1 with rsp_rdata=prdata.
  - Next command still accepted normally.
- **Timeout.** TIMEOUT=4, pready held low.
  - psel drops and rsp_valid/rsp_err=1 are asserted 5 cycles after ACCESS entry, with rsp_rdata=0.
  - cmd_ready is high in that cycle.
- **Back-to-back.** cmd_valid held high for 3 commands, pready=1.
  - Commands accepted every 3 cycles; exactly 3 rsp_valid pulses, in order.
- **Reset mid-ACCESS.** presetn pulled low while penable=1.
  - psel/penable drop immediately and no rsp_valid is emitted.
  - After release, cmd_ready=1 and the next command completes correctly.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encodings, default bus widths and the
// helper that sizes the ACCESS wait counter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b11
    } apb_state_e;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 32;

    // Bits needed to count 0..timeout; a disabled timeout still gets one bit.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response port plus APB3 bus of the APB requester, bundled so the
// requester, the slave and harnesses share one set of signal names.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_master_timer.sv
// Saturating wait-cycle counter for the ACCESS phase; flags expiry once the
// count reaches TIMEOUT (never flags when TIMEOUT is 0).
module apb_master_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = timer_width(TIMEOUT);

    logic [W-1:0] count_reg;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            assign expired = (count_reg == W'(TIMEOUT));
        end
    endgenerate

endmodule

// File: rtl/apb_master.sv
// APB3 requester: accepts one valid/ready command at a time, runs the
// SETUP/ACCESS sequence and returns a single-cycle response pulse.
module apb_master
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    apb_master_if.master  bus
);
    apb_state_e            state_reg;
    logic                  psel_reg;
    logic                  penable_reg;
    logic                  pwrite_reg;
    logic [ADDR_WIDTH-1:0] paddr_reg;
    logic [DATA_WIDTH-1:0] pwdata_reg;
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                  rsp_err_reg;

    logic                  accept;
    logic                  timer_clear;
    logic                  timer_enable;
    logic                  timer_expired;

    assign accept       = (state_reg == IDLE) && bus.cmd_valid;
    assign timer_clear  = accept;
    assign timer_enable = (state_reg == ACCESS) && !bus.pready;

    apb_master_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg     <= IDLE;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        pwrite_reg <= bus.cmd_write;
                        paddr_reg  <= bus.cmd_addr;
                        pwdata_reg <= bus.cmd_wdata;
                        psel_reg   <= 1'b1;
                        state_reg  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    // A completing slave wins over a timeout in the same cycle.
                    if (bus.pready) begin
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= bus.pslverr;
                        rsp_rdata_reg <= pwrite_reg ? '0 : bus.prdata;
                        state_reg     <= IDLE;
                    end else if (timer_expired) begin
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_rdata_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    psel_reg    <= 1'b0;
                    penable_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.psel      = psel_reg;
    assign bus.penable   = penable_reg;
    assign bus.pwrite    = pwrite_reg;
    assign bus.paddr     = paddr_reg;
    assign bus.pwdata    = pwdata_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4): bench plays the APB slave and
// command source, checking cycle-exact bus activity and responses.
module tb_apb_master;

    logic pclk;
    logic presetn;
    int   tests_run;
    int   tests_failed;

    apb_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    apb_master #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Every observation and stimulus change happens 1 ns after a rising edge.
    task automatic next_cycle();
        @(posedge pclk);
        #1;
    endtask

    // Issue one command from IDLE; slave holds pready low for 'waits' ACCESS cycles.
    task automatic do_cmd(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int waits,
                          input logic [31:0] rd, input logic err);
        logic [31:0] exp_rdata;
        exp_rdata     = w ? 32'h0 : rd;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prdata    = 32'h0;
        check($sformatf("%s_ready", tag), 64'(bus.cmd_ready), 64'd1);
        next_cycle();
        bus.cmd_valid = 1'b0;
        check($sformatf("%s_setup", tag), 64'({bus.psel, bus.penable, bus.rsp_valid}), 64'(3'b100));
        check($sformatf("%s_addr", tag), 64'(bus.paddr), 64'(a));
        check($sformatf("%s_wdata", tag), 64'({bus.pwrite, bus.pwdata}), 64'({w, d}));
        next_cycle();
        check($sformatf("%s_access", tag), 64'({bus.psel, bus.penable, bus.cmd_ready}), 64'(3'b110));
        for (int i = 0; i < waits; i++) begin
            bus.pslverr = 1'b1;
            next_cycle();
            check($sformatf("%s_hold%0d", tag, i),
                  64'({bus.paddr, bus.penable, bus.rsp_valid}), 64'({a, 2'b10}));
        end
        bus.pready  = 1'b1;
        bus.prdata  = rd;
        bus.pslverr = err;
        next_cycle();
        check($sformatf("%s_rsp", tag), 64'({bus.rsp_valid, bus.rsp_err, bus.psel, bus.cmd_ready}),
              64'({1'b1, err, 2'b01}));
        check($sformatf("%s_rdata", tag), 64'(bus.rsp_rdata), 64'(exp_rdata));
        $display("[TB] %s: %s addr=%08h rdata=%08h err=%0b", tag, w ? "write" : "read",
                 a, bus.rsp_rdata, bus.rsp_err);
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = 32'h0;
        next_cycle();
        check($sformatf("%s_pulse", tag), 64'(bus.rsp_valid), 64'd0);
        check($sformatf("%s_hold_rsp", tag), 64'({bus.rsp_rdata, bus.rsp_err}), 64'({exp_rdata, err}));
    endtask

    initial begin
        int pulses;
        tests_run     = 0;
        tests_failed  = 0;
        presetn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.prdata    = 32'h0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        check("rst_ctrl", 64'({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.cmd_ready}),
              64'(6'b000001));
        check("rst_data", 64'({bus.paddr, bus.pwdata}), 64'd0);
        check("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
        presetn = 1'b1;
        next_cycle();

        do_cmd("write0", 1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0);
        do_cmd("read2", 1'b0, 32'h20, 32'h0, 2, 32'h12345678, 1'b0);
        do_cmd("slverr", 1'b0, 32'h30, 32'h0, 0, 32'hCAFEF00D, 1'b1);
        do_cmd("after_err", 1'b1, 32'h40, 32'h000055AA, 1, 32'h0, 1'b0);

        // Timeout: ACCESS entered in cycle 2, abort visible in cycle 7
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h50;
        bus.pready    = 1'b0;
        bus.prdata    = 32'hFFFF0000;
        next_cycle();
        bus.cmd_valid = 1'b0;
        for (int cyc = 2; cyc <= 6; cyc++) begin
            next_cycle();
            check($sformatf("tmo_wait_c%0d", cyc), 64'({bus.psel, bus.penable, bus.rsp_valid}), 64'(3'b110));
        end
        next_cycle();
        check("tmo_rsp", 64'({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.cmd_ready}),
              64'(5'b00111));
        check("tmo_rdata", 64'(bus.rsp_rdata), 64'd0);
        $display("[TB] timeout: read addr=00000050 err=%0b", bus.rsp_err);
        bus.prdata = 32'h0;
        next_cycle();
        check("tmo_pulse", 64'({bus.rsp_valid, bus.rsp_err}), 64'(2'b01));

        // Back-to-back: accepts at edges 0, 3, 6; responses in cycles 3, 6, 9
        pulses        = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h60;
        bus.pready    = 1'b1;
        bus.pslverr   = 1'b0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            next_cycle();
            bus.prdata = 32'hBEEF0000 | bus.paddr;
            if (cyc == 1) bus.cmd_addr = 32'h64;
            if (cyc == 4) bus.cmd_addr = 32'h68;
            if (cyc == 7) bus.cmd_valid = 1'b0;
            check($sformatf("b2b_rsp_c%0d", cyc), 64'(bus.rsp_valid),
                  64'((cyc % 3 == 0) && (cyc <= 9)));
            if ((cyc % 3 == 1) && (cyc <= 7))
                check($sformatf("b2b_setup_c%0d", cyc), 64'({bus.psel, bus.penable}), 64'(2'b10));
            if (bus.rsp_valid) begin
                check($sformatf("b2b_rdata%0d", pulses), 64'(bus.rsp_rdata),
                      64'(32'hBEEF0060 + 32'(4 * pulses)));
                $display("[TB] b2b%0d: read rdata=%08h", pulses, bus.rsp_rdata);
                pulses++;
            end
        end
        check("b2b_pulses", 64'(pulses), 64'd3);
        bus.pready = 1'b0;
        bus.prdata = 32'h0;

        // Reset in the middle of ACCESS
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h70;
        bus.cmd_wdata = 32'h11111111;
        next_cycle();
        bus.cmd_valid = 1'b0;
        next_cycle();
        check("rst_mid_access", 64'({bus.psel, bus.penable}), 64'(2'b11));
        #3;
        presetn = 1'b0;
        #1;
        check("rst_mid_drop", 64'({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}), 64'(4'b0001));
        check("rst_mid_regs", 64'({bus.paddr, bus.pwrite}), 64'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h99;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check($sformatf("rst_quiet%0d", i), 64'({bus.psel, bus.rsp_valid}), 64'd0);
        end
        bus.cmd_valid = 1'b0;
        #2;
        presetn = 1'b1;
        next_cycle();
        check("rst_release", 64'({bus.psel, bus.rsp_valid, bus.cmd_ready}), 64'(3'b001));
        $display("[TB] reset mid-access: transfer dropped");
        do_cmd("post_rst", 1'b0, 32'h74, 32'h0, 1, 32'h600D600D, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
